// File: rtl/gmii_pkg.sv
// Shared GMII receive/transmit constants: preamble/SFD bytes, reflected CRC-32
// parameters and the receive framer state encoding.
package gmii_pkg;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

  // Bytes held back so the trailing FCS never reaches the consumer.
  localparam logic [15:0] HOLD_BYTES    = 16'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    DATA = 2'd2,
    DROP = 2'd3
  } rx_state_e;

endpackage

// File: rtl/crc32_d8.sv
// Combinational byte-wide update of the reflected CRC-32, data consumed LSB first.
// Shared between the receive framer and the transmit FCS generator.
module crc32_d8
  import gmii_pkg::*;
(
  input  logic [7:0]  data_i,
  input  logic [31:0] crc_i,
  output logic [31:0] crc_o
);

  always_comb begin
    logic [31:0] c;
    c = crc_i;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data_i[i]) c = (c >> 1) ^ CRC32_POLY;
      else                  c = c >> 1;
    end
    crc_o = c;
  end

endmodule

// File: rtl/gmii_rx_framer.sv
// GMII receive framer: strips preamble/SFD and FCS, checks CRC and length, flags frame verdict.
// Define GMII_RX_STATS_EN to build the good/CRC-error/length-error frame counters.
module gmii_rx_framer
  import gmii_pkg::*;
#(
  parameter int MIN_FRAME = 64,
  parameter int MAX_FRAME = 1522
) (
  input  logic        clk_div,
  input  logic        reset,
  input  logic [7:0]  rxd,
  input  logic        rxdv,
  input  logic        rxer,
  output logic [7:0]  m_data,
  output logic        m_valid,
  output logic        m_sof,
  output logic        m_eof,
  output logic        m_good,
  output logic [15:0] m_len,
  output logic [31:0] stat_good,
  output logic [31:0] stat_crc_err,
  output logic [31:0] stat_len_err
);

  localparam logic [15:0] MIN_LEN = 16'(MIN_FRAME);
  localparam logic [15:0] MAX_LEN = 16'(MAX_FRAME);

  rx_state_e       state_q;
  logic [31:0]     crc_q, crc_d;
  logic [4:0][7:0] dly_q;
  logic [15:0]     len_q, len_d;
  logic            err_flag_q;

  logic [7:0]      m_data_q;
  logic            m_valid_q, m_sof_q, m_eof_q, m_good_q;
  logic [15:0]     m_len_q;

  logic            start_frame, close_frame, fill_ok, crc_ok, len_ok, frame_good;

  crc32_d8 u_crc (
    .data_i (rxd),
    .crc_i  (crc_q),
    .crc_o  (crc_d)
  );

  // len saturates and only grows, so len >= 5 doubles as "delay line full".
  assign len_d       = (len_q == 16'hFFFF) ? len_q : len_q + 16'd1;
  assign fill_ok     = (len_q >= HOLD_BYTES);
  assign crc_ok      = (crc_q == CRC32_RESIDUE);
  assign len_ok      = (len_q >= MIN_LEN) && (len_q <= MAX_LEN);
  assign frame_good  = crc_ok && !err_flag_q && len_ok;
  assign close_frame = (state_q == DATA) && !rxdv;
  assign start_frame = rxdv && (rxd == SFD_BYTE) &&
                       ((state_q == IDLE) || ((state_q == PRE) && !rxer));

  always_ff @(posedge clk_div or posedge reset) begin
    if (reset) begin
      state_q    <= DROP;
      crc_q      <= CRC32_INIT;
      dly_q      <= '0;
      len_q      <= '0;
      err_flag_q <= 1'b0;
      m_data_q   <= '0;
      m_valid_q  <= 1'b0;
      m_sof_q    <= 1'b0;
      m_eof_q    <= 1'b0;
      m_good_q   <= 1'b0;
      m_len_q    <= '0;
    end else begin
      m_valid_q <= 1'b0;
      m_sof_q   <= 1'b0;
      m_eof_q   <= 1'b0;
      m_good_q  <= 1'b0;
      m_len_q   <= '0;

      if (start_frame) begin
        crc_q      <= CRC32_INIT;
        len_q      <= '0;
        err_flag_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (rxdv) begin
            if (rxd == PREAMBLE_BYTE) state_q <= PRE;
            else if (rxd == SFD_BYTE) state_q <= DATA;
            else                      state_q <= DROP;
          end
        end
        PRE: begin
          if (!rxdv)                     state_q <= IDLE;
          else if (rxer)                 state_q <= DROP;
          else if (rxd == PREAMBLE_BYTE) state_q <= PRE;
          else if (rxd == SFD_BYTE)      state_q <= DATA;
          else                           state_q <= DROP;
        end
        DATA: begin
          if (rxdv) begin
            crc_q      <= crc_d;
            dly_q      <= {dly_q[3:0], rxd};
            len_q      <= len_d;
            err_flag_q <= err_flag_q | rxer;
            if (fill_ok) begin
              m_valid_q <= 1'b1;
              m_data_q  <= dly_q[4];
              m_sof_q   <= (len_q == HOLD_BYTES);
            end
          end else begin
            state_q <= IDLE;
            // Oldest held byte is the last payload byte; the other four are FCS.
            if (fill_ok) begin
              m_valid_q <= 1'b1;
              m_data_q  <= dly_q[4];
              m_sof_q   <= (len_q == HOLD_BYTES);
              m_eof_q   <= 1'b1;
              m_good_q  <= frame_good;
              m_len_q   <= len_q;
            end
          end
        end
        default: begin
          if (!rxdv) state_q <= IDLE;
        end
      endcase
    end
  end

  assign m_data  = m_data_q;
  assign m_valid = m_valid_q;
  assign m_sof   = m_sof_q;
  assign m_eof   = m_eof_q;
  assign m_good  = m_good_q;
  assign m_len   = m_len_q;

`ifdef GMII_RX_STATS_EN
  logic [31:0] stat_good_q, stat_crc_err_q, stat_len_err_q;

  always_ff @(posedge clk_div or posedge reset) begin
    if (reset) begin
      stat_good_q    <= '0;
      stat_crc_err_q <= '0;
      stat_len_err_q <= '0;
    end else if (close_frame) begin
      // Runts never produce an eof but still count as length errors.
      if (fill_ok && frame_good)   stat_good_q    <= stat_good_q + 32'd1;
      if (fill_ok && !crc_ok)      stat_crc_err_q <= stat_crc_err_q + 32'd1;
      if (!fill_ok || !len_ok)     stat_len_err_q <= stat_len_err_q + 32'd1;
    end
  end

  assign stat_good    = stat_good_q;
  assign stat_crc_err = stat_crc_err_q;
  assign stat_len_err = stat_len_err_q;
`else
  assign stat_good    = '0;
  assign stat_crc_err = '0;
  assign stat_len_err = '0;
`endif

endmodule

// File: tb/tb_gmii_rx_framer.sv
// Scoreboard bench for gmii_rx_framer: driver pushes expected payload bytes, monitor pops and compares.
`timescale 1ns/1ps
module tb_gmii_rx_framer;

  logic        clk_div = 1'b0;
  logic        reset   = 1'b0;
  logic [7:0]  rxd     = 8'h00;
  logic        rxdv    = 1'b0;
  logic        rxer    = 1'b0;
  logic [7:0]  m_data;
  logic        m_valid, m_sof, m_eof, m_good;
  logic [15:0] m_len;
  logic [31:0] stat_good, stat_crc_err, stat_len_err;

  gmii_rx_framer #(.MIN_FRAME(64), .MAX_FRAME(1522)) dut (
    .clk_div      (clk_div),
    .reset        (reset),
    .rxd          (rxd),
    .rxdv         (rxdv),
    .rxer         (rxer),
    .m_data       (m_data),
    .m_valid      (m_valid),
    .m_sof        (m_sof),
    .m_eof        (m_eof),
    .m_good       (m_good),
    .m_len        (m_len),
    .stat_good    (stat_good),
    .stat_crc_err (stat_crc_err),
    .stat_len_err (stat_len_err)
  );

  always #5 clk_div = ~clk_div;

`ifdef GMII_RX_STATS_EN
  localparam bit STATS_ON = 1'b1;
`else
  localparam bit STATS_ON = 1'b0;
`endif

  typedef struct packed {
    logic [7:0]  data;
    logic        sof;
    logic        eof;
    logic        good;
    logic [15:0] len;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] fb[$];
  int         n_cmp = 0;
  int         n_err = 0;
  int         e_good = 0, e_crc = 0, e_len = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int b = 0; b < 8; b++)
      r = (r[0] ^ d[b]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  // Frame of 'total' bytes (DA..FCS) with a correct FCS appended LSB first.
  task automatic build(input int total, input int seed);
    logic [31:0] c;
    logic [7:0]  b;
    fb.delete();
    c = 32'hFFFFFFFF;
    for (int i = 0; i < total - 4; i++) begin
      b = 8'((i * 13 + seed * 29 + 7) & 255);
      fb.push_back(b);
      c = crc_upd(c, b);
    end
    c = ~c;
    for (int i = 0; i < 4; i++) fb.push_back(8'(c >> (8 * i)));
  endtask

  // Expected output: every byte but the last four, eof on the last one.
  task automatic push_frame(input bit good);
    int n;
    n = fb.size() - 4;
    for (int i = 0; i < n; i++)
      sb.push_back('{data: fb[i], sof: (i == 0), eof: (i == n - 1),
                     good: good, len: 16'(fb.size())});
  endtask

  task automatic cyc(input logic dv, input logic [7:0] d, input logic er);
    @(posedge clk_div); #1;
    rxdv = dv; rxd = d; rxer = er;
  endtask

  task automatic tx(input int npre, input int er_at, input int gap);
    for (int i = 0; i < npre; i++) cyc(1'b1, 8'h55, 1'b0);
    cyc(1'b1, 8'hD5, 1'b0);
    foreach (fb[i]) cyc(1'b1, fb[i], (i == er_at));
    for (int i = 0; i < gap; i++) cyc(1'b0, 8'h00, 1'b0);
  endtask

  task automatic chk_stats(input string tag);
    repeat (2) @(posedge clk_div);
    #2;
    check({tag, "_stat_good"}, 64'(stat_good),    STATS_ON ? 64'(e_good) : 64'd0);
    check({tag, "_stat_crc"},  64'(stat_crc_err), STATS_ON ? 64'(e_crc)  : 64'd0);
    check({tag, "_stat_len"},  64'(stat_len_err), STATS_ON ? 64'(e_len)  : 64'd0);
  endtask

  task automatic chk_out_zero(input string tag);
    check({tag, "_out"}, 64'({m_data, m_valid, m_sof, m_eof, m_good, m_len}), 64'd0);
  endtask

  // Monitor: every presented byte must match the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_div);
      if (m_valid) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_byte: got data %0h sof %0b eof %0b, expected no output at %0t",
                   m_data, m_sof, m_eof, $time);
        end else begin
          e = sb.pop_front();
          check("out_data",  64'(m_data), 64'(e.data));
          check("out_flags", 64'({m_sof, m_eof}), 64'({e.sof, e.eof}));
          if (e.eof) begin
            check("out_good", 64'(m_good), 64'(e.good));
            check("out_len",  64'(m_len),  64'(e.len));
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected run to finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #1 reset = 1'b1;
    #2 chk_out_zero("reset");
    repeat (3) @(posedge clk_div);
    #1 reset = 1'b0;
    chk_stats("reset");

    // Minimum-size good frame
    build(64, 1); push_frame(1'b1); tx(7, -1, 2); e_good++; chk_stats("good64");

    // Same frame, one payload bit flipped after FCS was computed
    build(64, 1); fb[10] = fb[10] ^ 8'h04; push_frame(1'b0); tx(7, -1, 2);
    e_crc++; chk_stats("crc_bad");

    // Runt with valid CRC
    build(40, 2); push_frame(1'b0); tx(7, -1, 2); e_len++; chk_stats("len40");

    // Oversize by one, then exactly maximum
    build(1523, 3); push_frame(1'b0); tx(7, -1, 2); e_len++; chk_stats("len1523");
    build(1522, 4); push_frame(1'b1); tx(7, -1, 2); e_good++; chk_stats("len1522");

    // rxer mid-payload: bad verdict, no counter moves
    build(64, 5); push_frame(1'b0); tx(7, 20, 2); chk_stats("rxer_data");

    // rxer with rxdv low is ignored
    repeat (4) cyc(1'b0, 8'h0F, 1'b1);
    cyc(1'b0, 8'h00, 1'b0);
    chk_stats("rxer_idle");

    // Broken preamble drops everything until rxdv falls, even a later D5
    cyc(1'b1, 8'h55, 1'b0); cyc(1'b1, 8'h55, 1'b0); cyc(1'b1, 8'hAA, 1'b0);
    cyc(1'b1, 8'hD5, 1'b0);
    for (int i = 0; i < 10; i++) cyc(1'b1, 8'(i + 1), 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
    // SFD-only frame afterwards
    build(64, 6); push_frame(1'b1); tx(0, -1, 2); e_good++; chk_stats("bad_pre");

    // 3-byte runt: silent drop, length error; then 5-byte frame after a 1-cycle gap
    fb.delete(); fb.push_back(8'h11); fb.push_back(8'h22); fb.push_back(8'h33);
    tx(7, -1, 1); e_len++;
    build(5, 7); push_frame(1'b0); tx(7, -1, 2); e_len++; chk_stats("runt");

    // Reset at byte 30, released at byte 35; bytes 0..23 escape beforehand
    build(64, 8);
    for (int i = 0; i < 24; i++)
      sb.push_back('{data: fb[i], sof: (i == 0), eof: 1'b0, good: 1'b0, len: 16'd0});
    for (int i = 0; i < 7; i++) cyc(1'b1, 8'h55, 1'b0);
    cyc(1'b1, 8'hD5, 1'b0);
    foreach (fb[i]) begin
      @(posedge clk_div); #1;
      rxdv = 1'b1; rxd = fb[i]; rxer = 1'b0;
      if (i == 30) reset = 1'b1;
      if (i == 35) reset = 1'b0;
      if (reset) begin
        #3 chk_out_zero("midrst");
      end
    end
    cyc(1'b0, 8'h00, 1'b0);
    e_good = 0; e_crc = 0; e_len = 0;
    build(64, 9); push_frame(1'b1); tx(7, -1, 2); e_good++; chk_stats("post_rst");

    repeat (10) @(posedge clk_div);
    #2 check("sb_drained", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
